// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants and state types for the memory-mapped UART transmitter.
package mmio_uart_tx_pkg;

   // Register offsets, word index d_addr[3:2]
   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_DIV    = 2'd2;
   localparam logic [1:0] OFF_CTRL   = 2'd3;

   // STATUS bit positions
   localparam int ST_FULL  = 0;
   localparam int ST_EMPTY = 1;
   localparam int ST_BUSY  = 2;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} bus_state_e;
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO; push ignored when full, pop ignored when empty.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         din_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // Storage array; contents need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data port.
// Optional interrupt output and CTRL.irq_en enabled by defining UART_TX_IRQ_EN.
module mmio_uart_tx #(
   parameter int                  WORD_LEN     = 32,
   parameter logic [WORD_LEN-1:0] BASE_ADDR    = 32'hF000_0000,
   parameter int                  FIFO_DEPTH   = 16,
   parameter int                  CLKS_PER_BIT = 78
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req,
   input  logic [WORD_LEN-1:0] d_addr,
   input  logic                wen,
   input  logic [WORD_LEN-1:0] wmask,
   input  logic [WORD_LEN-1:0] wdata,
   output logic [WORD_LEN-1:0] rdata,
   output logic                data_ready,
   output logic                tx
`ifdef UART_TX_IRQ_EN
   ,output logic               irq
`endif
);
   import mmio_uart_tx_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   bus_state_e          bus_q, bus_d;
   ser_state_e          ser_q, ser_d;
   logic [WORD_LEN-1:0] rdata_q, rdata_d, rd_val, status_w;
   logic                dready_q, dready_d;
   logic [15:0]         div_q, div_d;
   logic                push, pop, full, empty;
   logic [CW-1:0]       count;
   logic [7:0]          fifo_dout;
   logic [7:0]          shreg_q, shreg_d;
   logic [15:0]         divl_q, divl_d, cnt_q, cnt_d;
   logic [2:0]          bit_q, bit_d;
   logic                tx_q, tx_d, bit_end;
   logic                hit, push_req;
   logic [1:0]          off;
`ifdef UART_TX_IRQ_EN
   logic                irq_en_q, irq_en_d, irq_q;
`endif

   logic unused_bits;
   assign unused_bits = ^{d_addr[1:0], wmask[WORD_LEN-1:16], wdata[WORD_LEN-1:16]};

   assign hit      = (d_addr[WORD_LEN-1:4] == BASE_ADDR[WORD_LEN-1:4]);
   assign off      = d_addr[3:2];
   assign push_req = hit & wen & (off == OFF_TXDATA) & (wmask[7:0] == 8'hFF);
   assign bit_end  = (cnt_q == divl_q);

   uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (wdata[7:0]),
      .dout_o  (fifo_dout),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   // Register read mux; TXDATA and unmapped bits read as zero
   always_comb begin
      status_w           = '0;
      status_w[ST_FULL]  = full;
      status_w[ST_EMPTY] = empty;
      status_w[ST_BUSY]  = (ser_q != S_IDLE);
      status_w[15:8]     = {{(8-CW){1'b0}}, count};
      rd_val             = '0;
      case (off)
         OFF_STATUS: rd_val = status_w;
         OFF_DIV:    rd_val = WORD_LEN'(div_q);
`ifdef UART_TX_IRQ_EN
         OFF_CTRL:   rd_val = WORD_LEN'(irq_en_q);
`endif
         default:    rd_val = '0;
      endcase
   end

   // Bus FSM: single-cycle access, or stall in WAIT while a push finds the FIFO full
   always_comb begin
      bus_d    = bus_q;
      rdata_d  = '0;
      dready_d = 1'b0;
      push     = 1'b0;
      div_d    = div_q;
`ifdef UART_TX_IRQ_EN
      irq_en_d = irq_en_q;
`endif
      case (bus_q)
         IDLE: if (req) begin
            if (push_req && full) begin
               bus_d = WAIT;
            end else begin
               bus_d    = RESP;
               dready_d = 1'b1;
               push     = push_req;
               if (hit && !wen) rdata_d = rd_val;
               if (hit && wen && off == OFF_DIV)
                  div_d = (div_q & ~wmask[15:0]) | (wdata[15:0] & wmask[15:0]);
`ifdef UART_TX_IRQ_EN
               if (hit && wen && off == OFF_CTRL && wmask[0])
                  irq_en_d = wdata[0];
`endif
            end
         end
         WAIT: if (!full) begin
            push     = 1'b1;
            bus_d    = RESP;
            dready_d = 1'b1;
         end
         RESP:    bus_d = IDLE;
         default: bus_d = IDLE;
      endcase
   end

   // Serializer: latch byte and divisor on pop; chain straight into the next frame
   always_comb begin
      ser_d   = ser_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      divl_d  = divl_q;
      pop     = 1'b0;
      tx_d    = 1'b1;
      case (ser_q)
         S_IDLE: if (!empty) begin
            pop     = 1'b1;
            shreg_d = fifo_dout;
            divl_d  = div_q;
            cnt_d   = '0;
            ser_d   = S_START;
         end
         S_START: begin
            tx_d = 1'b0;
            if (bit_end) begin
               cnt_d = '0;
               bit_d = '0;
               ser_d = S_DATA;
            end else cnt_d = cnt_q + 1'b1;
         end
         S_DATA: begin
            tx_d = shreg_q[0];
            if (bit_end) begin
               cnt_d   = '0;
               shreg_d = {1'b0, shreg_q[7:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == 3'd7) ser_d = S_STOP;
            end else cnt_d = cnt_q + 1'b1;
         end
         S_STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               if (!empty) begin
                  pop     = 1'b1;
                  shreg_d = fifo_dout;
                  divl_d  = div_q;
                  ser_d   = S_START;
               end else ser_d = S_IDLE;
            end else cnt_d = cnt_q + 1'b1;
         end
         default: ser_d = S_IDLE;
      endcase
   end

   // State and output registers; reset aborts any frame or stalled access
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_q    <= IDLE;
         rdata_q  <= '0;
         dready_q <= 1'b0;
         div_q    <= 16'(CLKS_PER_BIT - 1);
         ser_q    <= S_IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         shreg_q  <= '0;
         divl_q   <= '0;
         tx_q     <= 1'b1;
      end else begin
         bus_q    <= bus_d;
         rdata_q  <= rdata_d;
         dready_q <= dready_d;
         div_q    <= div_d;
         ser_q    <= ser_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shreg_q  <= shreg_d;
         divl_q   <= divl_d;
         tx_q     <= tx_d;
      end
   end

`ifdef UART_TX_IRQ_EN
   // Interrupt when enabled and the transmitter has fully drained
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         irq_en_q <= irq_en_d;
         irq_q    <= irq_en_q & empty & (ser_q == S_IDLE);
      end
   end
   assign irq = irq_q;
`endif

   assign rdata      = rdata_q;
   assign data_ready = dready_q;
   assign tx         = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: bus accesses plus a tx-line frame decoder
// checked against a queue of expected bytes.
module tb_mmio_uart_tx;
   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [31:0] d_addr, wmask, wdata, rdata;
   logic        wen, data_ready, tx;
`ifdef UART_TX_IRQ_EN
   logic        irq;
`endif

   int          checks = 0;
   int          failures = 0;
   logic [7:0]  sb[$];
   int          bit_clks = 78;

   localparam logic [31:0] A_TX = 32'hF000_0000;
   localparam logic [31:0] A_ST = 32'hF000_0004;
   localparam logic [31:0] A_DV = 32'hF000_0008;
   localparam logic [31:0] A_CT = 32'hF000_000C;
   localparam logic [31:0] ONES = 32'hFFFF_FFFF;

   mmio_uart_tx dut (
      .clk(clk), .rst(rst), .req(req), .d_addr(d_addr), .wen(wen),
      .wmask(wmask), .wdata(wdata), .rdata(rdata), .data_ready(data_ready),
      .tx(tx)
`ifdef UART_TX_IRQ_EN
      , .irq(irq)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] m,
                      input logic [31:0] d, output logic [31:0] rd, output int lat);
      @(negedge clk);
      req = 1'b1; d_addr = a; wen = w; wmask = m; wdata = d; lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (data_ready !== 1'b1 && lat < 300);
      rd = rdata;
      if (data_ready !== 1'b1) chk("bus_timeout", {63'b0, data_ready}, 64'd1);
      req = 1'b0; wen = 1'b0; wmask = '0; wdata = '0; d_addr = '0;
   endtask

   // Frame decoder: samples mid-bit, drops any frame that saw reset
   initial begin : mon
      logic [9:0] fr;
      logic [7:0] eb;
      bit         ab;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && tx === 1'b0) begin
            ab = 1'b0;
            for (int k = 0; k < bit_clks/2; k++) begin @(negedge clk); if (rst) ab = 1'b1; end
            fr[0] = tx;
            for (int b = 1; b < 10; b++) begin
               for (int k = 0; k < bit_clks; k++) begin @(negedge clk); if (rst) ab = 1'b1; end
               fr[b] = tx;
            end
            for (int k = 0; k < bit_clks - bit_clks/2 - 1; k++) begin @(negedge clk); if (rst) ab = 1'b1; end
            if (!ab) begin
               if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
               else begin
                  eb = sb.pop_front();
                  chk("frame", {54'b0, fr}, {54'b0, 1'b1, eb, 1'b0});
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      int          lat, bad;
      logic [39:0] got, expw;
      logic [9:0]  fb;

      rst = 1'b1; req = 1'b0; d_addr = '0; wen = 1'b0; wmask = '0; wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_rdata", rdata, 0);
      chk("rst_ready", data_ready, 0);
      chk("rst_tx", tx, 1);
`ifdef UART_TX_IRQ_EN
      chk("rst_irq", irq, 0);
`endif
      rst = 1'b0;

      bus(A_DV, 0, '0, '0, r, lat);  chk("div_reset", r, 77); chk("div_lat", lat, 1);
      bus(A_ST, 0, '0, '0, r, lat);  chk("status_reset", r, 32'h2); chk("status_lat", lat, 1);
      bus(A_TX, 0, '0, '0, r, lat);  chk("txdata_read", r, 0);
`ifndef UART_TX_IRQ_EN
      bus(A_CT, 1, ONES, 32'h1, r, lat);
      bus(A_CT, 0, '0, '0, r, lat);  chk("ctrl_ro", r, 0);
`else
      bus(A_CT, 0, '0, '0, r, lat);  chk("ctrl_reset", r, 0);
`endif
      bus(A_DV, 1, ONES, 32'hFFFF_0003, r, lat);
      bit_clks = 4;
      bus(A_DV, 0, '0, '0, r, lat);  chk("div_write", r, 32'h3);

      // A5 frame timing, sampled every clock from two cycles after the push edge
      sb.push_back(8'hA5);
      bus(A_TX, 1, ONES, 32'hA5, r, lat); chk("a5_lat", lat, 1);
      chk("a5_tx_push", tx, 1);
      @(negedge clk); chk("a5_tx_plus1", tx, 1);
      fb = {1'b1, 8'hA5, 1'b0};
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         got[j]  = tx;
         expw[j] = fb[j/4];
      end
      chk("a5_frame_wave", got, expw);

      // Partial mask completes but does not enqueue
      bus(A_TX, 1, 32'h0000_000F, 32'h77, r, lat); chk("mask0f_lat", lat, 1);
      bus(A_ST, 0, '0, '0, r, lat);  chk("mask0f_status", r, 32'h2);
      sb.push_back(8'h3C);
      bus(A_TX, 1, 32'h0000_00FF, 32'h3C, r, lat); chk("maskff_lat", lat, 1);
      bus(A_ST, 0, '0, '0, r, lat);  chk("maskff_status", r, 32'h6);
      repeat (50) @(negedge clk);

      // Misses complete with zero data and leave state alone
      bus(32'hF000_0010, 0, '0, '0, r, lat); chk("miss_rdata", r, 0); chk("miss_lat", lat, 1);
      bus(32'hF000_0018, 1, ONES, 32'h55, r, lat); chk("miss_wr_lat", lat, 1);
      bus(32'hF000_0010, 1, ONES, 32'h99, r, lat);
      bus(A_DV, 0, '0, '0, r, lat);  chk("miss_div", r, 32'h3);
      bus(A_ST, 0, '0, '0, r, lat);  chk("miss_status", r, 32'h2);

      // Fill: first byte goes straight to the serializer, 16 more fill the FIFO
      bad = 0;
      for (int i = 0; i < 17; i++) begin
         sb.push_back(8'(8'h10 + i));
         bus(A_TX, 1, ONES, 32'(8'h10 + i), r, lat);
         if (lat != 1) bad++;
      end
      chk("fill_lat", bad, 0);
      bus(A_ST, 0, '0, '0, r, lat);  chk("full_status", r, 32'h1005);
      sb.push_back(8'h21);
      bus(A_TX, 1, ONES, 32'h21, r, lat); chk("stall_lat", lat, 7);
      bus(A_ST, 0, '0, '0, r, lat);  chk("refill_status", r, 32'h1005);
      repeat (720) @(negedge clk);
      chk("sb_drain", sb.size(), 0);
      bus(A_ST, 0, '0, '0, r, lat);  chk("drained_status", r, 32'h2);

`ifdef UART_TX_IRQ_EN
      bus(A_CT, 1, ONES, 32'h1, r, lat);
      bus(A_CT, 0, '0, '0, r, lat);  chk("ctrl_rw", r, 32'h1);
      @(negedge clk); chk("irq_idle", irq, 1);
      sb.push_back(8'h5A);
      bus(A_TX, 1, ONES, 32'h5A, r, lat);
      bad = 0;
      for (int j = 1; j <= 41; j++) begin
         @(negedge clk);
         if (irq !== 1'b0) bad++;
      end
      chk("irq_low_frame", bad, 0);
      chk("irq_stop_tx", tx, 1);
      @(negedge clk); chk("irq_after_stop", irq, 1);
`endif

      // Reset mid-frame: line returns high at once, FIFO and DIV reinitialised
      bus(A_TX, 1, ONES, 32'hC3, r, lat);
      bus(A_TX, 1, ONES, 32'hC4, r, lat);
      repeat (12) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_tx", tx, 1);
      chk("midrst_ready", data_ready, 0);
`ifdef UART_TX_IRQ_EN
      chk("midrst_irq", irq, 0);
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bus(A_ST, 0, '0, '0, r, lat);  chk("postrst_status", r, 32'h2);
      bus(A_DV, 0, '0, '0, r, lat);  chk("postrst_div", r, 77);
      chk("postrst_tx", tx, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
